// File: rtl/conv_mem_arbiter.sv
// conv_mem_arbiter
//   Shares the single CONV layer memory port between two requesters:
//   requester 0 (convolution stage) and requester 1 (max-pool stage).
//   Legal layer selects are 3'b001 (L0 conv output) and 3'b011 (L1 max-pool
//   output). One transaction is granted per cycle. The memory strobes are
//   registered, and read data is routed back to the requester that issued
//   the read.
//
// Configuration macro:
//   CONV_ARB_FIXED_PRIO_EN - when defined, the round-robin pointer is removed
//                            and requester 0 always wins unlocked contention.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-low reset
//   req        in   [NREQ]     per-requester request, held until granted
//   lock       in   [NREQ]     per-requester burst lock (owner only)
//   we         in   [NREQ]     per-requester direction (1 write, 0 read)
//   sel        in   [3*NREQ]   per-requester layer select {sel1,sel0}
//   addr       in   [NREQ*AW]  per-requester address {addr1,addr0}
//   wdata      in   [NREQ*DW]  per-requester write data {wdata1,wdata0}
//   gnt        out  [NREQ]     one-hot combinational grant
//   rvalid     out  [NREQ]     one-hot read-data-valid, registered
//   rdata      out  [DW]       read data, valid with any rvalid bit
//   err        out             one-cycle pulse: granted request had illegal sel
//   crd / cwr  out             memory read / write strobes, registered
//   csel       out  [3]        memory layer select, registered
//   caddr_rd   out  [AW]       memory read address, registered
//   caddr_wr   out  [AW]       memory write address, registered
//   cdata_wr   out  [DW]       memory write data, registered
//   cdata_rd   in   [DW]       memory read data, sampled in the crd cycle
//   dbg_state  out  [2]        ownership state (0 IDLE, 1 OWN0, 2 OWN1)
//
// Handshake: a transaction is accepted at the rising edge where
// req[i] & gnt[i] is high. gnt is a pure function of the current inputs
// and ownership state, and the requester holds we/sel/addr/wdata stable
// from raising req[i] until that edge. There is no backpressure on the
// read-return path: rvalid[i] is a one-cycle pulse.

module conv_mem_arbiter #(
  parameter int NREQ = 2,
  parameter int AW   = 12,
  parameter int DW   = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    lock,
  input  logic [NREQ-1:0]    we,
  input  logic [3*NREQ-1:0]  sel,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    rvalid,
  output logic [DW-1:0]      rdata,
  output logic               err,
  output logic               crd,
  output logic               cwr,
  output logic [2:0]         csel,
  output logic [AW-1:0]      caddr_rd,
  output logic [AW-1:0]      caddr_wr,
  output logic [DW-1:0]      cdata_wr,
  input  logic [DW-1:0]      cdata_rd,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

`ifndef CONV_ARB_FIXED_PRIO_EN
  // Points at the requester that wins the next unlocked contention.
  logic r_ptr;
`endif

  logic [NREQ-1:0] w_gnt;
  logic            w_gid;
  logic            w_accept;
  logic            w_legal;
  logic            w_we;
  logic [2:0]      w_sel;
  logic [AW-1:0]   w_addr;
  logic [DW-1:0]   w_wdata;
  logic            w_lock0;
  logic            w_lock1;

  logic            r_crd;
  logic            r_cwr;
  logic            r_err;
  logic [2:0]      r_csel;
  logic [AW-1:0]   r_caddr_rd;
  logic [AW-1:0]   r_caddr_wr;
  logic [DW-1:0]   r_cdata_wr;
  logic            r_tag_vld;
  logic            r_tag_id;
  logic [NREQ-1:0] r_rvalid;
  logic [DW-1:0]   r_rdata;

  // Ownership / grant decision. Lock is honoured only for the current owner
  // and only while it still requests; otherwise the policy picks a winner.
  always_comb begin
    w_gnt        = '0;
    w_gid        = 1'b0;
    w_next_state = ST_IDLE;
    w_lock0      = (r_state == ST_OWN0) && lock[0] && req[0];
    w_lock1      = (r_state == ST_OWN1) && lock[1] && req[1];
    if (!reset) begin
      w_gnt = '0;
    end else if (w_lock0) begin
      w_gnt = 2'b01;
    end else if (w_lock1) begin
      w_gnt = 2'b10;
    end else if (req == 2'b11) begin
`ifdef CONV_ARB_FIXED_PRIO_EN
      w_gnt = 2'b01;
`else
      w_gnt = r_ptr ? 2'b10 : 2'b01;
`endif
    end else begin
      w_gnt = req;
    end
    if (w_gnt[1]) begin
      w_gid        = 1'b1;
      w_next_state = ST_OWN1;
    end else if (w_gnt[0]) begin
      w_gid        = 1'b0;
      w_next_state = ST_OWN0;
    end
  end

  // Fields of the granted requester.
  always_comb begin
    w_accept = |w_gnt;
    w_we     = w_gid ? we[1]               : we[0];
    w_sel    = w_gid ? sel[5:3]            : sel[2:0];
    w_addr   = w_gid ? addr[2*AW-1:AW]     : addr[AW-1:0];
    w_wdata  = w_gid ? wdata[2*DW-1:DW]    : wdata[DW-1:0];
    w_legal  = (w_sel == 3'b001) || (w_sel == 3'b011);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
`ifndef CONV_ARB_FIXED_PRIO_EN
      r_ptr   <= 1'b0;
`endif
    end else begin
      r_state <= w_next_state;
`ifndef CONV_ARB_FIXED_PRIO_EN
      // The loser (or the requester that did not take the grant) goes next.
      if (w_accept) begin
        r_ptr <= ~w_gid;
      end
`endif
    end
  end

  // Memory command stage plus the two-stage read tag pipeline:
  // tag stage lines up with crd, the rvalid stage captures cdata_rd.
  // Illegal selects are granted (no deadlock) but issue no strobe.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_crd      <= 1'b0;
      r_cwr      <= 1'b0;
      r_err      <= 1'b0;
      r_csel     <= 3'b000;
      r_caddr_rd <= '0;
      r_caddr_wr <= '0;
      r_cdata_wr <= '0;
      r_tag_vld  <= 1'b0;
      r_tag_id   <= 1'b0;
      r_rvalid   <= '0;
      r_rdata    <= '0;
    end else begin
      r_crd     <= w_accept && w_legal && !w_we;
      r_cwr     <= w_accept && w_legal && w_we;
      r_err     <= w_accept && !w_legal;
      r_tag_vld <= w_accept && w_legal && !w_we;
      r_tag_id  <= w_gid;
      if (w_accept && w_legal) begin
        r_csel <= w_sel;
        if (w_we) begin
          r_caddr_wr <= w_addr;
          r_cdata_wr <= w_wdata;
        end else begin
          r_caddr_rd <= w_addr;
        end
      end
      r_rvalid <= r_tag_vld ? {r_tag_id, ~r_tag_id} : 2'b00;
      if (r_tag_vld) begin
        r_rdata <= cdata_rd;
      end
    end
  end

  assign gnt       = w_gnt;
  assign crd       = r_crd;
  assign cwr       = r_cwr;
  assign err       = r_err;
  assign csel      = r_csel;
  assign caddr_rd  = r_caddr_rd;
  assign caddr_wr  = r_caddr_wr;
  assign cdata_wr  = r_cdata_wr;
  assign rvalid    = r_rvalid;
  assign rdata     = r_rdata;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_conv_mem_arbiter.sv
// Bench for conv_mem_arbiter: directed scenarios followed by randomized
// traffic. A reference model (owner / round-robin pointer / reference
// memory) predicts each grant; accepted transactions push expected memory
// commands and read returns into queues that a negedge monitor pops.

module tb_conv_mem_arbiter;

  localparam int AW = 12;
  localparam int DW = 20;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [1:0]        req;
  logic [1:0]        lock;
  logic [1:0]        we;
  logic [5:0]        sel;
  logic [2*AW-1:0]   addr;
  logic [2*DW-1:0]   wdata;
  logic [1:0]        gnt;
  logic [1:0]        rvalid;
  logic [DW-1:0]     rdata;
  logic              err;
  logic              crd;
  logic              cwr;
  logic [2:0]        csel;
  logic [AW-1:0]     caddr_rd;
  logic [AW-1:0]     caddr_wr;
  logic [DW-1:0]     cdata_wr;
  logic [DW-1:0]     cdata_rd;
  logic [1:0]        dbg_state;

  conv_mem_arbiter #(.NREQ(2), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .we(we), .sel(sel),
    .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .err(err), .crd(crd), .cwr(cwr), .csel(csel), .caddr_rd(caddr_rd),
    .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .cdata_rd(cdata_rd),
    .dbg_state(dbg_state)
  );

  // Memory attached to the DUT port: asynchronous read, write on clock edge.
  logic [DW-1:0] mem [0:8191];
  always @(posedge clk) if (cwr) mem[{csel[1], caddr_wr}] <= cdata_wr;
  assign cdata_rd = mem[{csel[1], caddr_rd}];

  // scoreboard
  // command entry: {kind[1:0], csel[2:0], addr[AW-1:0], data[DW-1:0]}
  // kind 1 = write, 2 = read, 3 = illegal-select error
  logic [36:0] exp_q[$];
  // read return entry: {id, data}
  logic [20:0] exp_rd_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic note_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // reference model
  int            m_owner;
  bit            m_ptr;
  logic [2:0]    m_last_sel;
  logic [DW-1:0] ref_mem [0:8191];

  function automatic logic [1:0] model_grant();
    logic [1:0] one;
    one = 2'b01;
    if (!reset) return 2'b00;
    if (m_owner >= 0 && lock[m_owner] && req[m_owner]) return one << m_owner;
    if (req == 2'b11) begin
`ifdef CONV_ARB_FIXED_PRIO_EN
      return 2'b01;
`else
      return m_ptr ? 2'b10 : 2'b01;
`endif
    end
    return req;
  endfunction

  task automatic model_reset();
    m_owner    = -1;
    m_ptr      = 1'b0;
    m_last_sel = 3'b000;
    exp_q.delete();
    exp_rd_q.delete();
  endtask

  task automatic model_commit(input logic [1:0] g);
    int id;
    logic [2:0]    s;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    if (g == 2'b00) begin
      m_owner = -1;
      return;
    end
    id      = g[1] ? 1 : 0;
    m_owner = id;
    m_ptr   = (id == 0);
    s = sel[id*3 +: 3];
    a = addr[id*AW +: AW];
    d = wdata[id*DW +: DW];
    if (s == 3'b001 || s == 3'b011) begin
      m_last_sel = s;
      if (we[id]) begin
        exp_q.push_back({2'd1, s, a, d});
        ref_mem[{s[1], a}] = d;
      end else begin
        exp_q.push_back({2'd2, s, a, {DW{1'b0}}});
        exp_rd_q.push_back({id[0], ref_mem[{s[1], a}]});
      end
    end else begin
      exp_q.push_back({2'd3, m_last_sel, {AW{1'b0}}, {DW{1'b0}}});
    end
  endtask

  // monitor
  always @(negedge clk) begin : monitor
    logic [36:0] e;
    logic [20:0] r;
    logic [1:0]  kind;
    if (reset === 1'b1) begin
      if (crd || cwr || err) begin
        check("strobe_onehot", $countones({crd, cwr, err}), 1);
        kind = cwr ? 2'd1 : (crd ? 2'd2 : 2'd3);
        if (exp_q.size() == 0) begin
          note_fail("unexpected_cmd");
        end else begin
          e = exp_q.pop_front();
          check("cmd_kind", kind, e[36:35]);
          check("cmd_csel", csel, e[34:32]);
          if (kind == 2'd1) begin
            check("caddr_wr", caddr_wr, e[31:20]);
            check("cdata_wr", cdata_wr, e[19:0]);
          end else if (kind == 2'd2) begin
            check("caddr_rd", caddr_rd, e[31:20]);
          end
        end
      end
      if (rvalid != 2'b00) begin
        if (exp_rd_q.size() == 0) begin
          note_fail("unexpected_rvalid");
        end else begin
          r = exp_rd_q.pop_front();
          check("rvalid_id", rvalid, r[20] ? 2'b10 : 2'b01);
          check("rdata", rdata, r[19:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic set_req(input int i, input bit r, input bit lk, input bit w,
                         input logic [2:0] s, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req[i]            = r;
    lock[i]           = lk;
    we[i]             = w;
    sel[i*3 +: 3]     = s;
    addr[i*AW +: AW]  = a;
    wdata[i*DW +: DW] = d;
  endtask

  // Called just after a negedge: checks gnt, takes the edge, returns at the
  // following negedge.
  task automatic step(output logic [1:0] g_model, output logic [1:0] g_obs);
    #1;
    g_model = model_grant();
    g_obs   = gnt;
    check("gnt", g_obs, g_model);
    @(posedge clk);
    model_commit(g_model);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    logic [1:0] gm, go;
    req  = 2'b00;
    lock = 2'b00;
    repeat (n) step(gm, go);
  endtask

  task automatic do_reset(input int n);
    #2;
    reset = 1'b0;
    req   = 2'b00;
    lock  = 2'b00;
    repeat (n) @(negedge clk);
    model_reset();
    reset = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"}, gnt, 2'b00);
    check({tag, "_crd_cwr"}, {crd, cwr}, 2'b00);
    check({tag, "_csel"}, csel, 3'b000);
    check({tag, "_rvalid"}, rvalid, 2'b00);
    check({tag, "_err"}, err, 1'b0);
    check({tag, "_addrs"}, {caddr_rd, caddr_wr}, 24'h0);
    check({tag, "_data"}, {cdata_wr, rdata}, 40'h0);
  endtask

  // random requester state
  bit            p_valid [2];
  bit            p_we    [2];
  logic [2:0]    p_sel   [2];
  logic [AW-1:0] p_addr  [2];
  logic [DW-1:0] p_wdata [2];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [1:0] gm, go;
    logic [1:0] pat;
    int v;

    for (int i = 0; i < 8192; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    model_reset();
    reset = 1'b0;
    req   = 2'b11;
    lock  = 2'b00;
    we    = 2'b00;
    sel   = {3'b001, 3'b001};
    addr  = '0;
    wdata = '0;

    // reset held for three cycles with both requesting
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      check_reset_outputs("reset");
    end
    @(negedge clk);
    model_reset();
    reset = 1'b1;
    req   = 2'b00;

    // write then read the same address
    set_req(0, 1, 0, 1, 3'b001, 12'h040, 20'h0ABCD);
    step(gm, go);
    check("wr_lat_cwr", cwr, 1'b1);
    check("wr_lat_addr", caddr_wr, 12'h040);
    set_req(0, 1, 0, 0, 3'b001, 12'h040, 20'h0);
    step(gm, go);
    check("rd_lat_crd", crd, 1'b1);
    req = 2'b00;
    step(gm, go);
    check("rd_lat_rvalid", rvalid, 2'b01);
    check("rd_lat_rdata", rdata, 20'h0ABCD);
    idle(3);

    // contention without lock
    do_reset(2);
    set_req(0, 1, 0, 1, 3'b001, 12'h100, 20'h11111);
    set_req(1, 1, 0, 1, 3'b011, 12'h200, 20'h22222);
    for (int k = 0; k < 6; k++) begin
      step(gm, go);
`ifdef CONV_ARB_FIXED_PRIO_EN
      pat = 2'b01;
`else
      pat = (k % 2 == 0) ? 2'b01 : 2'b10;
`endif
      check("contention_pattern", go, pat);
    end
    idle(3);

    // lock held by requester 1 for four reads while requester 0 waits
    do_reset(2);
    set_req(1, 1, 1, 0, 3'b011, 12'h200, 20'h0);
    step(gm, go);
    check("lock_first", go, 2'b10);
    set_req(0, 1, 0, 1, 3'b001, 12'h300, 20'h33333);
    for (int k = 1; k < 4; k++) begin
      set_req(1, 1, 1, 0, 3'b011, 12'h200 + k[AW-1:0], 20'h0);
      step(gm, go);
      check("lock_hold", go, 2'b10);
    end
    lock[1] = 1'b0;
    step(gm, go);
    check("lock_release", go, 2'b01);
    idle(4);

    // illegal select
    do_reset(2);
    set_req(0, 1, 0, 1, 3'b011, 12'h055, 20'h05555);
    step(gm, go);
    set_req(0, 1, 0, 0, 3'b010, 12'h055, 20'h0);
    step(gm, go);
    check("illegal_gnt", go, 2'b01);
    check("illegal_err", err, 1'b1);
    check("illegal_strobes", {crd, cwr}, 2'b00);
    check("illegal_csel", csel, 3'b011);
    req = 2'b00;
    step(gm, go);
    check("illegal_no_rvalid", rvalid, 2'b00);
    check("illegal_err_pulse", err, 1'b0);
    idle(2);

    // reset during the crd cycle of a read
    do_reset(2);
    set_req(0, 1, 0, 0, 3'b001, 12'h040, 20'h0);
    step(gm, go);
    check("midrst_crd", crd, 1'b1);
    req = 2'b00;
    #2;
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    model_reset();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(gm, go);
      check("midrst_no_rvalid", rvalid, 2'b00);
    end

    // randomized traffic
    do_reset(2);
    p_valid[0] = 0;
    p_valid[1] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!p_valid[i] && $urandom_range(0, 3) != 0) begin
          p_valid[i] = 1;
          p_we[i]    = $urandom_range(0, 1);
          v = $urandom_range(0, 9);
          if (v < 4) p_sel[i] = 3'b001;
          else if (v < 8) p_sel[i] = 3'b011;
          else begin
            p_sel[i] = 3'($urandom_range(0, 7));
            if (p_sel[i] == 3'b001 || p_sel[i] == 3'b011) p_sel[i] = 3'b110;
          end
          p_addr[i]  = AW'($urandom_range(0, 15));
          p_wdata[i] = DW'($urandom);
        end
        set_req(i, p_valid[i], ($urandom_range(0, 2) == 0), p_we[i],
                p_sel[i], p_addr[i], p_wdata[i]);
      end
      step(gm, go);
      for (int i = 0; i < 2; i++) if (gm[i]) p_valid[i] = 0;
    end
    idle(5);
    check("cmd_queue_drained", exp_q.size(), 0);
    check("rd_queue_drained", exp_rd_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_mem_arbiter.md
# conv_mem_arbiter

Single-port arbiter for the CONV layer memory (L0 conv output at csel 3'b001, L1 max-pool output at csel 3'b011). Two internal requesters share the one memory port: requester 0 is the convolution stage and requester 1 is the max-pool stage. The block grants one transaction per cycle and drives the registered crd/cwr/csel/address/data strobes toward the memory. It also returns read data to the requester that issued the read.

## Interface
- NREQ, 2, number of requesters (fixed at 2 in this revision)
- AW, 12, memory address width
- DW, 20, memory data width
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- req  in  2  per-requester transaction request, held until granted
- lock  in  2  per-requester burst lock, meaningful only while that requester owns the port
- we  in  2  per-requester direction (1 write, 0 read)
- sel  in  6  per-requester layer select, {sel1,sel0}, 3 bits each
- addr  in  24  per-requester address, {addr1,addr0}
- wdata  in  40  per-requester write data, {wdata1,wdata0}
- gnt  out  2  one-hot grant, combinational, accepted at the closing clock edge
- rvalid  out  2  one-hot read-data-valid, registered
- rdata  out  20  read data, valid when any rvalid bit is set
- err  out  1  one-cycle pulse: a granted request carried an illegal sel
- crd  out  1  memory read strobe, registered
- cwr  out  1  memory write strobe, registered
- csel  out  3  memory layer select, registered
- caddr_rd  out  12  memory read address, registered
- caddr_wr  out  12  memory write address, registered
- cdata_wr  out  20  memory write data, registered
- cdata_rd  in  20  memory read data, valid at the rising edge one cycle after crd is sampled high

## Operation
- At most one gnt bit is high per cycle. The grant is a handshake: a transaction is accepted at the rising edge when req[i]&gnt[i] is high. The requester must hold req, we, sel, addr and wdata stable until it is granted.
- Ownership state: IDLE, OWN0, OWN1.
  - IDLE → OWNi on a grant to requester i.
  - OWNi with lock[i]&req[i] high: requester i keeps the grant unconditionally.
  - OWNi with lock[i] low: policy arbitration runs every cycle, and ownership moves to the winner.
  - Any state with no req high → IDLE.
- Policy is round-robin. The pointer points at the requester that lost or did not take the last grant. When both requesters request and no lock is active, the pointed-to requester wins. The pointer updates only on a grant.
- Accepted write: next cycle cwr=1, csel=sel, caddr_wr=addr, cdata_wr=wdata, crd=0.
- Accepted read: next cycle crd=1, csel=sel, caddr_rd=addr, cwr=0. The requester ID is tagged into a 2-stage pipeline. rdata is captured from cdata_rd one cycle later, and rvalid[id] goes high for exactly one cycle.
- Legal sel values are 3'b001 and 3'b011.
  - Any other sel is still granted, to avoid deadlock.
  - No crd or cwr is issued for it, and csel holds its previous value.
  - err pulses in the cycle after the grant, and no rvalid is produced.
- With no accepted transaction, crd=cwr=0 next cycle. csel, the addresses and cdata_wr hold their previous values.
- Transactions reach memory in grant order, so a read granted after a write to the same address returns the new data.

## Timing
- Reset (reset=0 at a rising edge):
  - crd=cwr=0, csel=3'b000, caddr_rd=caddr_wr=0, cdata_wr=0, rdata=0, rvalid=0, err=0.
  - State goes to IDLE and the round-robin pointer goes to requester 0.
  - gnt is forced to 0 while reset is low.
- Reset asserted mid-operation discards in-flight read tags: no rvalid appears afterward for reads granted before reset.
- Write latency: grant in cycle N, cwr high in cycle N+1, memory updates at the edge ending N+1.
- Read latency: grant in cycle N, crd high in cycle N+1, rvalid/rdata in cycle N+2. Throughput is one transaction per cycle, and back-to-back reads overlap.
- Requests arriving in the same cycle resolve by lock first, then by round-robin (or fixed priority, see Configuration).
- A lock held with req low releases ownership. A lock asserted by a non-owner is ignored.

## Configuration
- CONV_ARB_FIXED_PRIO_EN defined: the round-robin pointer is removed and requester 0 (conv) always wins unlocked contention. Lock semantics are unchanged.
- CONV_ARB_FIXED_PRIO_EN undefined: round-robin policy as described above.

## Test plan
- Reset: hold reset=0 for 3 cycles with req=2'b11 → gnt=0, crd=cwr=0, csel=0, rvalid=0 throughout.
- Write then read (req0: we=1, sel=001, addr=12'h040, wdata=20'h0ABCD; then we=0, same addr) → cwr in cycle N+1 with caddr_wr=040; rvalid[0] in read-grant cycle +2 with rdata=0ABCD.
- Contention (req=2'b11 continuously, no lock, 6 cycles) → grants alternate 01,10,01,10,…. With CONV_ARB_FIXED_PRIO_EN, gnt=01 every cycle.
- Lock: requester 1 owns the port with lock[1]=1 for 4 reads while req0 is high → gnt=10 for 4 cycles, then 01 the cycle after lock[1] falls.
- Illegal sel=3'b010 from requester 0 → granted, err=1 next cycle, crd=cwr=0, csel unchanged, no rvalid.
- Reset mid-read: grant a read, drop reset in the crd cycle → no rvalid, all outputs at reset values.
